// File: rtl/seek_arb_if.sv
// Bundle between the seek arbiter, its upstream requesters and the shared
// g unit: requester handshakes, unit issue/return, and routed results.
interface seek_arb_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 16
);
  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ*DATA_W-1:0]       req_c;
  logic [NREQ*(2*DATA_W+2)-1:0] req_z;
  logic [NREQ*DATA_W-1:0]       req_e;
  logic [NREQ*(DATA_W+3)-1:0]   req_f;

  logic                         u_en;
  logic [DATA_W-1:0]            u_c;
  logic [2*DATA_W+1:0]          u_z;
  logic [DATA_W-1:0]            u_e;
  logic [DATA_W+2:0]            u_f;
  logic                         u_rdy;
  logic [DATA_W+2:0]            u_g;

  logic [NREQ-1:0]              res_valid;
  logic [DATA_W+2:0]            res_g;

  // Arbiter side
  modport slave (
    input  req_valid, req_c, req_z, req_e, req_f, u_rdy, u_g,
    output req_ready, u_en, u_c, u_z, u_e, u_f, res_valid, res_g
  );

  // Environment side (requesters, shared unit, result consumers)
  modport master (
    output req_valid, req_c, req_z, req_e, req_f, u_rdy, u_g,
    input  req_ready, u_en, u_c, u_z, u_e, u_f, res_valid, res_g
  );
endinterface

// File: rtl/seek_arb.sv
// Round-robin arbiter sharing one g-computation unit among NREQ requesters.
// Grants are issued one per cycle, each issue is tracked through a LAT-deep
// tag line, and the returned g is routed to the requester that issued it.
module seek_arb #(
  parameter int NREQ   = 4,
  parameter int LAT    = 1,
  parameter int DATA_W = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     hold,
  seek_arb_if.slave bus,
  output logic     err
);
  localparam int IDW = $clog2(NREQ);
  localparam int ZW  = 2*DATA_W+2;
  localparam int FW  = DATA_W+3;

  logic [IDW-1:0] ptr_p0;
  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  logic           gnt;
  int             idx;

  logic [IDW-1:0] u_id_p0;

  logic [LAT-1:0] tag_vld_p1;
  logic [IDW-1:0] tag_id_p1 [LAT];
  logic           head_vld;
  logic [IDW-1:0] head_id;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int j = 0; j < NREQ; j++) begin
      idx = (int'(ptr_p0) + j) % NREQ;
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
  end

  assign gnt = gnt_any & ~hold & rst_n;

  // One-hot ready; the grant itself is the handshake for the chosen requester.
  always_comb begin
    bus.req_ready = '0;
    if (gnt) bus.req_ready[gnt_id] = 1'b1;
  end

  // ---- stage p0: issue to the shared unit, advance the round-robin pointer
  // Register the granted operand set, zero the operand bus when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_p0  <= '0;
      u_id_p0 <= '0;
      bus.u_en <= 1'b0;
      bus.u_c  <= '0;
      bus.u_z  <= '0;
      bus.u_e  <= '0;
      bus.u_f  <= '0;
    end else begin
      bus.u_en <= gnt;
      u_id_p0  <= gnt ? gnt_id : '0;
      bus.u_c  <= gnt ? bus.req_c[gnt_id*DATA_W +: DATA_W] : '0;
      bus.u_z  <= gnt ? bus.req_z[gnt_id*ZW     +: ZW]     : '0;
      bus.u_e  <= gnt ? bus.req_e[gnt_id*DATA_W +: DATA_W] : '0;
      bus.u_f  <= gnt ? bus.req_f[gnt_id*FW     +: FW]     : '0;
      if (gnt) begin
        if (int'(gnt_id) == NREQ-1) ptr_p0 <= '0;
        else                        ptr_p0 <= gnt_id + 1'b1;
      end
    end
  end

  // ---- stage p1: tag line, one entry pushed per cycle whether issued or not
  // Shift {issued, id} so the head lines up with the unit's return strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld_p1 <= '0;
      for (int k = 0; k < LAT; k++) tag_id_p1[k] <= '0;
    end else begin
      tag_vld_p1[0] <= bus.u_en;
      tag_id_p1[0]  <= u_id_p0;
      for (int k = 1; k < LAT; k++) begin
        tag_vld_p1[k] <= tag_vld_p1[k-1];
        tag_id_p1[k]  <= tag_id_p1[k-1];
      end
    end
  end

  assign head_vld = tag_vld_p1[LAT-1];
  assign head_id  = tag_id_p1[LAT-1];

  // ---- stage p2: route the returned g, flag any strobe/tag disagreement
  // A missing or unexpected strobe is a protocol error that sticks until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.res_valid <= '0;
      bus.res_g     <= '0;
      err           <= 1'b0;
    end else begin
      bus.res_valid <= '0;
      bus.res_g     <= '0;
      if (head_vld && bus.u_rdy) begin
        bus.res_valid[head_id] <= 1'b1;
        bus.res_g              <= bus.u_g;
      end
      if (head_vld != bus.u_rdy) err <= 1'b1;
    end
  end
endmodule
